// File: rtl/md5_job_scheduler.sv
// Hands out one starting character per MD5 cracker worker, refills idle workers, and stops
// the whole search on the first reported match or once the character range is exhausted.
module md5_job_scheduler #(
  parameter int         NUM_WORKERS = 4,
  parameter logic [7:0] FIRST_CHAR  = 8'h61,
  parameter logic [7:0] LAST_CHAR   = 8'h7A
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [127:0]               target_hash_i,
  output logic [NUM_WORKERS-1:0]     job_valid_o,
  output logic [7:0]                 job_start_char_o,
  output logic [127:0]               job_hash_o,
  input  logic [NUM_WORKERS-1:0]     worker_done_i,
  input  logic [NUM_WORKERS-1:0]     worker_found_i,
  input  logic [128*NUM_WORKERS-1:0] worker_plaintext_i,
  output logic                       abort_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       found_o,
  output logic [127:0]               plaintext_o
);

  typedef enum logic [1:0] {StIdle, StDispatch, StAbort, StFinish} state_e;

  // One extra bit so a LAST_CHAR of 8'hFF still terminates instead of wrapping.
  localparam logic [8:0] FirstNc = {1'b0, FIRST_CHAR};
  localparam logic [8:0] LastNc  = {1'b0, LAST_CHAR};

  state_e                 state_q, state_d;
  logic [8:0]             next_char_q, next_char_d;
  logic [NUM_WORKERS-1:0] out_q, out_d;
  logic [NUM_WORKERS-1:0] job_valid_q, job_valid_d;
  logic [7:0]             job_start_char_q, job_start_char_d;
  logic [127:0]           job_hash_q, job_hash_d;
  logic                   abort_q, abort_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   found_q, found_d;
  logic [127:0]           plaintext_q, plaintext_d;

  logic [NUM_WORKERS-1:0] match_vec;
  logic [NUM_WORKERS-1:0] free_onehot;
  logic [127:0]           match_pt;

  assign match_vec = worker_done_i & worker_found_i & out_q;

  // Descending scans so the lowest index wins.
  always_comb begin
    match_pt    = '0;
    free_onehot = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_pt = worker_plaintext_i[128*i +: 128];
      end
      if (!out_q[i]) begin
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    next_char_d      = next_char_q;
    out_d            = out_q;
    job_valid_d      = '0;
    job_start_char_d = '0;
    job_hash_d       = job_hash_q;
    abort_d          = 1'b0;
    busy_d           = busy_q;
    done_d           = 1'b0;
    found_d          = found_q;
    plaintext_d      = plaintext_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          job_hash_d  = target_hash_i;
          next_char_d = FirstNc;
          found_d     = 1'b0;
          plaintext_d = '0;
          out_d       = '0;
          busy_d      = 1'b1;
          state_d     = StDispatch;
        end
      end
      StDispatch: begin
        if (|match_vec) begin
          plaintext_d = match_pt;
          found_d     = 1'b1;
          out_d       = '0;
          abort_d     = 1'b1;
          state_d     = StAbort;
        end else if (next_char_q > LastNc && out_q == '0) begin
          done_d  = 1'b1;
          state_d = StFinish;
        end else begin
          // Dispatch uses the registered mask, so a worker freed this cycle waits one cycle.
          out_d = out_q & ~worker_done_i;
          if (next_char_q <= LastNc && free_onehot != '0) begin
            job_valid_d      = free_onehot;
            job_start_char_d = next_char_q[7:0];
            out_d            = out_d | free_onehot;
            next_char_d      = next_char_q + 9'd1;
          end
        end
      end
      StAbort: begin
        out_d   = '0;
        done_d  = 1'b1;
        state_d = StFinish;
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= StIdle;
      next_char_q      <= FirstNc;
      out_q            <= '0;
      job_valid_q      <= '0;
      job_start_char_q <= '0;
      job_hash_q       <= '0;
      abort_q          <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      found_q          <= 1'b0;
      plaintext_q      <= '0;
    end else begin
      state_q          <= state_d;
      next_char_q      <= next_char_d;
      out_q            <= out_d;
      job_valid_q      <= job_valid_d;
      job_start_char_q <= job_start_char_d;
      job_hash_q       <= job_hash_d;
      abort_q          <= abort_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      found_q          <= found_d;
      plaintext_q      <= plaintext_d;
    end
  end

  assign job_valid_o      = job_valid_q;
  assign job_start_char_o = job_start_char_q;
  assign job_hash_o       = job_hash_q;
  assign abort_o          = abort_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign found_o          = found_q;
  assign plaintext_o      = plaintext_q;

endmodule

// File: tb/tb_md5_job_scheduler.sv
// Directed bench: a four-worker scheduler for dispatch/refill/match/reset and a two-worker
// "a".."c" scheduler for range exhaustion.
module tb_md5_job_scheduler;

  localparam logic [127:0] Hash1 = 128'h5014bf4efb93a883b348004c9b90ddc6;
  localparam logic [127:0] Hash2 = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] PtAkha = 128'h616b6861;
  localparam logic [127:0] PtW0 = 128'h7730;
  localparam logic [127:0] PtW3 = 128'h7733;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  int           checks = 0;
  int           errors = 0;

  logic         start = 1'b0;
  logic [127:0] hash = '0;
  logic [3:0]   wdone = '0;
  logic [3:0]   wfound = '0;
  logic [511:0] wpt = '0;
  logic [3:0]   job_valid;
  logic [7:0]   job_char;
  logic [127:0] job_hash;
  logic         abort, busy, done, found;
  logic [127:0] plaintext;

  logic         start_x = 1'b0;
  logic [1:0]   wdone_x = '0;
  logic [1:0]   job_valid_x;
  logic [7:0]   job_char_x;
  logic [127:0] job_hash_x;
  logic         abort_x, busy_x, done_x, found_x;
  logic [127:0] plaintext_x;

  always #5 clk = ~clk;

  md5_job_scheduler dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .start_i            (start),
    .target_hash_i      (hash),
    .job_valid_o        (job_valid),
    .job_start_char_o   (job_char),
    .job_hash_o         (job_hash),
    .worker_done_i      (wdone),
    .worker_found_i     (wfound),
    .worker_plaintext_i (wpt),
    .abort_o            (abort),
    .busy_o             (busy),
    .done_o             (done),
    .found_o            (found),
    .plaintext_o        (plaintext)
  );

  md5_job_scheduler #(
    .NUM_WORKERS (2),
    .FIRST_CHAR  (8'h61),
    .LAST_CHAR   (8'h63)
  ) dut_x (
    .clk_i              (clk),
    .reset_i            (reset),
    .start_i            (start_x),
    .target_hash_i      (Hash2),
    .job_valid_o        (job_valid_x),
    .job_start_char_o   (job_char_x),
    .job_hash_o         (job_hash_x),
    .worker_done_i      (wdone_x),
    .worker_found_i     (2'b00),
    .worker_plaintext_i (256'h0),
    .abort_o            (abort_x),
    .busy_o             (busy_x),
    .done_o             (done_x),
    .found_o            (found_x),
    .plaintext_o        (plaintext_x)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_job_valid"}, 128'(job_valid), 128'h0);
    check({tag, "_job_char"}, 128'(job_char), 128'h0);
    check({tag, "_job_hash"}, job_hash, 128'h0);
    check({tag, "_abort"}, 128'(abort), 128'h0);
    check({tag, "_busy"}, 128'(busy), 128'h0);
    check({tag, "_done"}, 128'(done), 128'h0);
    check({tag, "_found"}, 128'(found), 128'h0);
    check({tag, "_plaintext"}, plaintext, 128'h0);
  endtask

  int         cnt [2];
  int         jobs;
  int         aborts;
  int         dones;
  logic       found_seen;
  logic [7:0] chars [3];
  logic [7:0] ch;

  initial begin
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Dispatch order: four jobs, one per cycle, then the pool is full.
    start = 1'b1;
    hash  = Hash1;
    tick();
    start = 1'b0;
    hash  = '0;
    check("c0_job_valid", 128'(job_valid), 128'h0);
    check("c0_busy", 128'(busy), 128'h1);
    check("c0_job_hash", job_hash, Hash1);
    ch = 8'h61;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("disp%0d_valid", k), 128'(job_valid), 128'(4'b0001 << k));
      check($sformatf("disp%0d_char", k), 128'(job_char), 128'(ch));
      ch = ch + 8'd1;
    end
    tick();
    check("c5_no_job", 128'(job_valid), 128'h0);

    // Refill: worker 2 completes, gets "e" two edges later.
    wdone = 4'b0100;
    tick();
    wdone = '0;
    check("c6_no_job", 128'(job_valid), 128'h0);
    tick();
    check("refill_valid", 128'(job_valid), 128'h4);
    check("refill_char", 128'(job_char), 128'h65);

    // Workers 0,1 free; worker 3 frees while worker 0 is being dispatched.
    wdone = 4'b0011;
    tick();
    wdone = 4'b1000;
    check("c8_no_job", 128'(job_valid), 128'h0);
    tick();
    wdone = '0;
    check("sim_w0_valid", 128'(job_valid), 128'h1);
    check("sim_w0_char", 128'(job_char), 128'h66);
    tick();
    check("sim_w1_valid", 128'(job_valid), 128'h2);
    check("sim_w1_char", 128'(job_char), 128'h67);
    tick();
    check("sim_w3_valid", 128'(job_valid), 128'h8);
    check("sim_w3_char", 128'(job_char), 128'h68);
    tick();
    check("full_no_job", 128'(job_valid), 128'h0);

    // Match on worker 1.
    wdone  = 4'b0010;
    wfound = 4'b0010;
    wpt[128 +: 128] = PtAkha;
    tick();
    wdone  = '0;
    wfound = '0;
    check("m1_found", 128'(found), 128'h1);
    check("m1_plaintext", plaintext, PtAkha);
    check("m1_abort", 128'(abort), 128'h1);
    check("m1_done", 128'(done), 128'h0);
    check("m1_no_job", 128'(job_valid), 128'h0);
    tick();
    check("m2_abort", 128'(abort), 128'h0);
    check("m2_done", 128'(done), 128'h1);
    check("m2_busy", 128'(busy), 128'h1);
    check("m2_no_job", 128'(job_valid), 128'h0);
    tick();
    check("m3_done", 128'(done), 128'h0);
    check("m3_busy", 128'(busy), 128'h0);
    check("m3_found_hold", 128'(found), 128'h1);
    check("m3_pt_hold", plaintext, PtAkha);

    // Second search: stray done on an idle worker is ignored, then two simultaneous matches.
    start = 1'b1;
    hash  = Hash2;
    tick();
    start = 1'b0;
    check("r2_found_clr", 128'(found), 128'h0);
    check("r2_pt_clr", plaintext, 128'h0);
    check("r2_hash", job_hash, Hash2);
    wdone  = 4'b0100;
    wfound = 4'b0100;
    tick();
    wdone  = '0;
    wfound = '0;
    check("stray_abort", 128'(abort), 128'h0);
    check("stray_found", 128'(found), 128'h0);
    check("stray_job", 128'(job_valid), 128'h1);
    tick();
    tick();
    tick();
    check("r2_w3_job", 128'(job_valid), 128'h8);
    wpt[0 +: 128]   = PtW0;
    wpt[384 +: 128] = PtW3;
    wdone  = 4'b1001;
    wfound = 4'b1001;
    tick();
    wdone  = '0;
    wfound = '0;
    check("dual_plaintext", plaintext, PtW0);
    check("dual_found", 128'(found), 128'h1);
    check("dual_abort", 128'(abort), 128'h1);
    tick();
    check("dual_done", 128'(done), 128'h1);
    tick();
    check("dual_busy", 128'(busy), 128'h0);

    // Third search interrupted by an asynchronous reset.
    start = 1'b1;
    hash  = Hash1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("r3_busy", 128'(busy), 128'h1);
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    tick();
    reset = 1'b0;
    check("post_reset_abort", 128'(abort), 128'h0);
    start = 1'b1;
    hash  = Hash2;
    tick();
    start = 1'b0;
    tick();
    check("restart_valid", 128'(job_valid), 128'h1);
    check("restart_char", 128'(job_char), 128'h61);
    check("restart_hash", job_hash, Hash2);

    // Exhaustion on the two-worker "a".."c" scheduler; each job completes 3 cycles after issue.
    cnt[0]     = 0;
    cnt[1]     = 0;
    jobs       = 0;
    aborts     = 0;
    dones      = 0;
    found_seen = 1'b1;
    for (int i = 0; i < 3; i++) chars[i] = 8'h00;
    start_x = 1'b1;
    tick();
    start_x = 1'b0;
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (job_valid_x[i]) begin
          if (jobs < 3) chars[jobs] = job_char_x;
          jobs++;
          cnt[i] = 3;
        end
      end
      if (abort_x) aborts++;
      if (done_x) begin
        dones++;
        found_seen = found_x;
      end
      wdone_x = '0;
      for (int i = 0; i < 2; i++) begin
        if (cnt[i] != 0) begin
          cnt[i]--;
          if (cnt[i] == 0) wdone_x[i] = 1'b1;
        end
      end
      tick();
    end
    wdone_x = '0;
    check("exh_jobs", 128'(jobs), 128'd3);
    check("exh_char0", 128'(chars[0]), 128'h61);
    check("exh_char1", 128'(chars[1]), 128'h62);
    check("exh_char2", 128'(chars[2]), 128'h63);
    check("exh_dones", 128'(dones), 128'd1);
    check("exh_found", 128'(found_seen), 128'h0);
    check("exh_aborts", 128'(aborts), 128'd0);
    check("exh_busy", 128'(busy_x), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_job_scheduler.md
# md5_job_scheduler

Distributes a brute-force MD5 preimage search across `NUM_WORKERS` MD5 cracker controllers. Each worker gets one starting character and searches its own slice of the plaintext space. The scheduler latches the target hash on `start` and issues slices one per cycle to idle workers. It captures the first matching plaintext, aborts all workers on a match, and reports completion when the space is exhausted or a match is found.

## Interface
- `NUM_WORKERS`, 4: number of cracker workers (1–8).
- `FIRST_CHAR`, 8'h61 ("a"): first starting character issued.
- `LAST_CHAR`, 8'h7A ("z"): last starting character issued, inclusive; requires `LAST_CHAR >= FIRST_CHAR`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a search; accepted only in IDLE.
- `target_hash`  in  128  hash to match; sampled on an accepted `start`.
- `job_valid`  out  `NUM_WORKERS`  one-hot, one-cycle pulse that assigns a slice to worker i.
- `job_start_char`  out  8  starting character for the assigned slice; valid while `job_valid` != 0.
- `job_hash`  out  128  latched target hash, driven to all workers.
- `worker_done`  in  `NUM_WORKERS`  one-cycle pulse: worker i finished its slice.
- `worker_found`  in  `NUM_WORKERS`  qualifies `worker_done[i]`: the slice produced a match.
- `worker_plaintext`  in  128*`NUM_WORKERS`  flattened; bits [128i+127:128i] belong to worker i.
- `abort`  out  1  one-cycle broadcast telling all workers to stop.
- `busy`  out  1  high from an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `found`  out  1  the search ended with a match; holds until the next accepted `start`.
- `plaintext`  out  128  matched plaintext; holds until the next accepted `start`.

## Operation
- States: IDLE, DISPATCH, ABORT, FINISH.
- **IDLE:** an accepted `start` does the following, then moves to DISPATCH:
  - latches `target_hash` into `job_hash`;
  - sets `next_char` to `FIRST_CHAR`;
  - clears `found`, `plaintext` and the outstanding mask;
  - sets `busy`.
- **DISPATCH:**
  - Per-worker outstanding bit `out[i]` is set when `job_valid[i]` is issued and cleared on `worker_done[i]`.
  - When `next_char <= LAST_CHAR` and some `out[i] == 0`, the scheduler issues `job_valid` to the lowest such i with `job_start_char = next_char`, then increments `next_char`.
  - `next_char` is 9 bits wide, so `LAST_CHAR = 8'hFF` terminates with no wrap.
  - At most one job is issued per cycle.
  - A worker whose done pulse arrives in cycle t is eligible for a new job in cycle t+1 at the earliest.
  - `worker_done[i]` while `out[i] == 0` is ignored.
- **Match:** on any `worker_done[i] & worker_found[i] & out[i]`:
  - `plaintext` latches the slice of the lowest such i, and `found` is set;
  - no job issues that cycle;
  - the next state is ABORT.
- **Exhaustion:** when `next_char > LAST_CHAR`, all `out` bits are 0 and no match is pending, the next state is FINISH with `found = 0`.
- **ABORT:** `abort = 1` for exactly one cycle; all `out` bits clear; `worker_done` is ignored; the next state is FINISH.
- **FINISH:** `done = 1` for one cycle; `busy` clears; the next state is IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE; `next_char = FIRST_CHAR`; `out = 0`;
  - `job_valid = 0`, `job_start_char = 0`, `job_hash = 0`;
  - `abort = 0`, `busy = 0`, `done = 0`, `found = 0`, `plaintext = 0`.
- Reset mid-search returns to IDLE immediately with the reset values above; no `abort` pulse is generated.
- With `start` accepted at edge 0, the first `job_valid` is visible in cycle 1. With all workers idle, jobs issue in cycles 1..`NUM_WORKERS` to workers 0..`NUM_WORKERS`-1.
- All outputs are registered.
- From a match `worker_done` in cycle t:
  - `found` and `plaintext` are valid from t+1;
  - `abort` is high in t+1;
  - `done` is high in t+2;
  - `busy` is low from t+3.
- From exhaustion detected in cycle t: `done` is high in t+1 and `busy` is low from t+2.
- Simultaneous events in one cycle:
  - a match beats dispatch;
  - a non-matching done plus a dispatch both take effect, but the freed worker is not the one dispatched.

## Test plan
- **Dispatch order:** reset; `start` with hash 5014bf4efb93a883b348004c9b90ddc6 and no worker responses -> `job_valid` = 0001, 0010, 0100, 1000 in cycles 1–4 with chars "a", "b", "c", "d". After that no further jobs issue.
- **Refill:** pulse `worker_done[2]` with `found = 0` in cycle 6 -> cycle 7 issues `job_valid = 0100` with char "e".
- **Exhaustion:** `FIRST_CHAR` = "a", `LAST_CHAR` = "c", `NUM_WORKERS` = 2; complete each job 3 cycles after issue with no match -> exactly 3 jobs; `done` pulses once with `found = 0`; `abort` never asserts.
- **Match:** worker 1 reports `worker_found` with plaintext "akha" -> `plaintext` = "akha" and `found = 1`; a one-cycle `abort` at t+1; `done` at t+2; no job issues after t.
- **Simultaneous matches:** workers 0 and 3 report found in the same cycle -> worker 0's plaintext is captured.
- **Reset and restart:** assert `reset` during DISPATCH -> all outputs return to reset values immediately. A subsequent `start` restarts at "a" on worker 0.
